// File: rtl/spi_leader_mc.sv
// spi_leader_mc: multi-target SPI leader.
// Serialises one DATA_LEN-bit word per valid/ready transaction and returns the
// received word. SPI mode (cpol/cpha), bit order, SCLK divider and burst hold are
// captured per word; a held burst keeps its chip select low between words.
// Ports:
//   clk, rst_n          system clock, asynchronous active-low reset
//   i_tx_valid/o_tx_ready  word handshake; i_tx_data word to send
//   i_cs_sel            target select (out-of-range value asserts no cs_n)
//   i_cpol, i_cpha      SPI mode for the word
//   i_lsb_first         1: bit 0 first, 0: MSB first (applies to tx and rx)
//   i_hold_cs           keep CS low after the word (burst)
//   i_cs_release        end a held burst without a new word
//   i_divider           SCLK half-period H = i_divider + 1 clk cycles
//   o_rx_valid/o_rx_data  one-cycle pulse with the received word (data held)
//   o_busy              leader not idle
//   o_sclk, o_mosi, i_miso, o_cs_n  SPI pins (cs_n active low)
module spi_leader_mc #(
  parameter int DATA_LEN  = 8,
  parameter int NUM_CS    = 4,
  parameter int DIV_WIDTH = 8,
  localparam int SELW     = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_tx_valid,
  output logic                 o_tx_ready,
  input  logic [DATA_LEN-1:0]  i_tx_data,
  input  logic [SELW-1:0]      i_cs_sel,
  input  logic                 i_cpol,
  input  logic                 i_cpha,
  input  logic                 i_lsb_first,
  input  logic                 i_hold_cs,
  input  logic                 i_cs_release,
  input  logic [DIV_WIDTH-1:0] i_divider,
  output logic                 o_rx_valid,
  output logic [DATA_LEN-1:0]  o_rx_data,
  output logic                 o_busy,
  output logic                 o_sclk,
  output logic                 o_mosi,
  input  logic                 i_miso,
  output logic [NUM_CS-1:0]    o_cs_n
);

  localparam int EW = $clog2(2 * DATA_LEN) + 1;
  localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DATA_LEN);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_SETUP = 3'd2;
  localparam logic [2:0] ST_XFER  = 3'd3;
  localparam logic [2:0] ST_HOLD  = 3'd4;
  localparam logic [2:0] ST_GAP   = 3'd5;
  localparam logic [2:0] ST_BURST = 3'd6;

  // Active-low one-cold select mask; an out-of-range select leaves all high.
  function automatic logic [NUM_CS-1:0] cs_mask(input logic [SELW-1:0] sel);
    logic [NUM_CS-1:0] m;
    m = '1;
    for (int i = 0; i < NUM_CS; i++) begin
      if (int'(sel) == i) m[i] = 1'b0;
      else                m[i] = 1'b1;
    end
    return m;
  endfunction

  logic [2:0]           r_state;
  logic [DIV_WIDTH-1:0] r_cnt;
  logic [DIV_WIDTH-1:0] r_div;
  logic [EW-1:0]        r_edge;
  logic [DATA_LEN-1:0]  r_tx_sh;
  logic [DATA_LEN-1:0]  r_rx_sh;
  logic [DATA_LEN-1:0]  r_rx_data;
  logic [SELW-1:0]      r_sel;
  logic                 r_cpol, r_cpha, r_lsb, r_hold;
  logic                 r_tx_ready, r_rx_valid, r_sclk, r_mosi;
  logic [NUM_CS-1:0]    r_cs_n;

  logic                 w_release, w_accept, w_tick, w_leading, w_sample, w_shift, w_tx_head;
  logic [EW-1:0]        w_edge_num;
  logic [DATA_LEN-1:0]  w_tx_next, w_rx_next;

  // A release in BURST wins over a new word, so ready drops in that same cycle.
  assign w_release  = (r_state == ST_BURST) & i_cs_release;
  assign o_tx_ready = r_tx_ready & ~w_release;
  assign w_accept   = i_tx_valid & o_tx_ready;
  assign w_tick     = (r_cnt == r_div);
  assign w_edge_num = r_edge + EW'(1);
  assign w_leading  = w_edge_num[0];
  // cpha=0 samples on leading edges and shifts on trailing ones (none after the last bit);
  // cpha=1 shifts on leading edges and samples on trailing ones.
  assign w_sample   = r_cpha ? ~w_leading : w_leading;
  assign w_shift    = r_cpha ? w_leading : (~w_leading & (w_edge_num != LAST_EDGE));
  assign w_tx_head  = r_lsb ? r_tx_sh[0] : r_tx_sh[DATA_LEN-1];
  assign w_tx_next  = r_lsb ? {1'b0, r_tx_sh[DATA_LEN-1:1]} : {r_tx_sh[DATA_LEN-2:0], 1'b0};
  assign w_rx_next  = r_lsb ? {i_miso, r_rx_sh[DATA_LEN-1:1]} : {r_rx_sh[DATA_LEN-2:0], i_miso};

  assign o_rx_valid = r_rx_valid;
  assign o_rx_data  = r_rx_data;
  assign o_busy     = (r_state != ST_IDLE);
  assign o_sclk     = r_sclk;
  assign o_mosi     = r_mosi;
  assign o_cs_n     = r_cs_n;

  // Transaction FSM: handshake, divider timing, sclk/mosi generation and rx capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_div      <= '0;
      r_edge     <= '0;
      r_tx_sh    <= '0;
      r_rx_sh    <= '0;
      r_rx_data  <= '0;
      r_sel      <= '0;
      r_cpol     <= 1'b0;
      r_cpha     <= 1'b0;
      r_lsb      <= 1'b0;
      r_hold     <= 1'b0;
      r_tx_ready <= 1'b1;
      r_rx_valid <= 1'b0;
      r_sclk     <= 1'b0;
      r_mosi     <= 1'b0;
      r_cs_n     <= '1;
    end else begin
      r_rx_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // Idle polarity follows the cpol input so it is settled before CS falls.
          r_sclk     <= i_cpol;
          r_mosi     <= 1'b0;
          r_cs_n     <= '1;
          r_tx_ready <= 1'b1;
          if (w_accept) begin
            r_tx_sh    <= i_tx_data;
            r_sel      <= i_cs_sel;
            r_cpol     <= i_cpol;
            r_cpha     <= i_cpha;
            r_lsb      <= i_lsb_first;
            r_hold     <= i_hold_cs;
            r_div      <= i_divider;
            r_tx_ready <= 1'b0;
            r_state    <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          r_state <= ST_SETUP;
          r_cnt   <= '0;
          r_edge  <= '0;
          r_rx_sh <= '0;
          r_sclk  <= r_cpol;
          r_cs_n  <= cs_mask(r_sel);
          if (!r_cpha) begin
            r_mosi  <= w_tx_head;
            r_tx_sh <= w_tx_next;
          end else begin
            r_mosi  <= 1'b0;
          end
        end
        ST_SETUP, ST_XFER: begin
          if (w_tick) begin
            r_cnt  <= '0;
            r_sclk <= ~r_sclk;
            r_edge <= w_edge_num;
            if (w_sample) r_rx_sh <= w_rx_next;
            if (w_shift) begin
              r_mosi  <= w_tx_head;
              r_tx_sh <= w_tx_next;
            end
            r_state <= (w_edge_num == LAST_EDGE) ? ST_HOLD : ST_XFER;
          end else begin
            r_cnt <= r_cnt + DIV_WIDTH'(1);
          end
        end
        ST_HOLD: begin
          if (w_tick) begin
            r_cnt      <= '0;
            r_rx_data  <= r_rx_sh;
            r_rx_valid <= 1'b1;
            r_mosi     <= 1'b0;
            if (r_hold) begin
              r_tx_ready <= 1'b1;
              r_state    <= ST_BURST;
            end else begin
              r_cs_n  <= '1;
              r_state <= ST_GAP;
            end
          end else begin
            r_cnt <= r_cnt + DIV_WIDTH'(1);
          end
        end
        ST_GAP: begin
          r_cs_n <= '1;
          if (w_tick) begin
            r_cnt      <= '0;
            r_tx_ready <= 1'b1;
            r_state    <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + DIV_WIDTH'(1);
          end
        end
        ST_BURST: begin
          if (w_release) begin
            r_cnt      <= '0;
            r_cs_n     <= '1;
            r_tx_ready <= 1'b0;
            r_state    <= ST_GAP;
          end else if (w_accept) begin
            // Burst target is kept: i_cs_sel is deliberately not latched here.
            r_tx_sh    <= i_tx_data;
            r_cpol     <= i_cpol;
            r_cpha     <= i_cpha;
            r_lsb      <= i_lsb_first;
            r_hold     <= i_hold_cs;
            r_div      <= i_divider;
            r_tx_ready <= 1'b0;
            r_state    <= ST_LOAD;
          end else begin
            r_state <= ST_BURST;
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_cs_n     <= '1;
          r_tx_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_leader_mc.sv
// Directed bench for spi_leader_mc: loopback and follower-model transfers in all
// modes, bit order, bursts, release, out-of-range select, reset mid-word, divider limits.
module tb_spi_leader_mc;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic [1:0] cs_sel = 2'd0;
  logic       cpol = 1'b0, cpha = 1'b0, lsb_first = 1'b0, hold_cs = 1'b0, cs_release = 1'b0;
  logic [7:0] divider = 8'd0;
  logic       miso;

  logic       o_tx_ready, o_rx_valid, o_busy, o_sclk, o_mosi;
  logic [7:0] o_rx_data;
  logic [3:0] o_cs_n;

  logic       o3_tx_ready, o3_rx_valid, o3_busy, o3_sclk, o3_mosi;
  logic [7:0] o3_rx_data;
  logic [2:0] o3_cs_n;

  int n_checks = 0, n_errors = 0, cyc = 0, t_acc = 0, t_rx = 0;

  // follower model / monitors
  logic       f_loop = 1'b1, f_bit = 1'b0, f_cpol = 1'b0, f_cpha = 1'b0, f_lsb = 1'b0;
  logic [7:0] f_word = 8'h00, f_rx = 8'h00;
  int         f_idx = 0, f_viol = 0, m_mosi_hi = 0, mon_cs_bad = 0, m3_bad = 0;
  logic       f_prev_sel = 1'b0, f_prev_sclk = 1'b0, f_prev_mosi = 1'b0, f_sel_now, f_lead;
  logic       mon_cs_en = 1'b0, mon3_en = 1'b0;
  logic [3:0] mon_cs_exp = 4'hF;

  assign miso = f_loop ? o_mosi : f_bit;

  spi_leader_mc #(.DATA_LEN(8), .NUM_CS(4), .DIV_WIDTH(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .i_tx_valid(tx_valid), .o_tx_ready(o_tx_ready),
    .i_tx_data(tx_data), .i_cs_sel(cs_sel), .i_cpol(cpol), .i_cpha(cpha),
    .i_lsb_first(lsb_first), .i_hold_cs(hold_cs), .i_cs_release(cs_release),
    .i_divider(divider), .o_rx_valid(o_rx_valid), .o_rx_data(o_rx_data),
    .o_busy(o_busy), .o_sclk(o_sclk), .o_mosi(o_mosi), .i_miso(miso), .o_cs_n(o_cs_n));

  // Second instance with three selects so that cs_sel = NUM_CS is representable.
  spi_leader_mc #(.DATA_LEN(8), .NUM_CS(3), .DIV_WIDTH(8)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .i_tx_valid(tx_valid), .o_tx_ready(o3_tx_ready),
    .i_tx_data(tx_data), .i_cs_sel(cs_sel), .i_cpol(cpol), .i_cpha(cpha),
    .i_lsb_first(lsb_first), .i_hold_cs(hold_cs), .i_cs_release(cs_release),
    .i_divider(divider), .o_rx_valid(o3_rx_valid), .o_rx_data(o3_rx_data),
    .o_busy(o3_busy), .o_sclk(o3_sclk), .o_mosi(o3_mosi), .i_miso(o3_mosi), .o_cs_n(o3_cs_n));

  always #5 clk = ~clk;

  // SPI follower: drives miso from f_word, captures mosi, flags mosi moving on a sample edge.
  always @(posedge clk) begin
    #2;
    f_sel_now = (o_cs_n != 4'hF);
    if (f_sel_now && !f_prev_sel) begin
      f_idx = 0;
      f_rx  = 8'h00;
      if (!f_cpha) begin
        f_bit = f_lsb ? f_word[0] : f_word[7];
        f_idx = 1;
      end
    end else if (f_sel_now && (o_sclk != f_prev_sclk)) begin
      f_lead = (o_sclk != f_cpol);
      if (f_lead == f_cpha) begin
        if (f_idx < 8) f_bit = f_lsb ? f_word[f_idx] : f_word[7 - f_idx];
        f_idx++;
      end else begin
        f_rx = f_lsb ? {o_mosi, f_rx[7:1]} : {f_rx[6:0], o_mosi};
        if (o_mosi != f_prev_mosi) f_viol++;
      end
    end
    if (o_mosi) m_mosi_hi++;
    if (mon_cs_en && (o_cs_n !== mon_cs_exp)) mon_cs_bad++;
    if (mon3_en && (o3_cs_n !== 3'b111)) m3_bad++;
    f_prev_sel  = f_sel_now;
    f_prev_sclk = o_sclk;
    f_prev_mosi = o_mosi;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic [1:0] s, input logic pl, input logic ph,
                      input logic lsb, input logic hold, input logic [7:0] dv);
    logic ok;
    tx_data = d; cs_sel = s; cpol = pl; cpha = ph; lsb_first = lsb; hold_cs = hold; divider = dv;
    f_cpol = pl; f_cpha = ph; f_lsb = lsb;
    tx_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      if (o_tx_ready) ok = 1'b1;
      tick();
    end
    tx_valid = 1'b0;
    t_acc = cyc;
    check("accept", {31'd0, ok}, 32'd1);
  endtask

  task automatic wait_rx(input string tag, input int maxc);
    logic got;
    got = 1'b0;
    for (int i = 0; i < maxc && !got; i++) begin
      tick();
      if (o_rx_valid) got = 1'b1;
    end
    t_rx = cyc;
    check({tag, "_rxv"}, {31'd0, got}, 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    logic done;
    done = 1'b0;
    for (int i = 0; i < 600 && !done; i++) begin
      tick();
      if (!o_busy && o_tx_ready) done = 1'b1;
    end
    check({tag, "_idle"}, {31'd0, done}, 32'd1);
  endtask

  initial begin
    int pulses;
    // Reset values
    tick(); tick();
    check("rst_ready", {31'd0, o_tx_ready}, 32'd1);
    check("rst_rxv",   {31'd0, o_rx_valid}, 32'd0);
    check("rst_rxd",   {24'd0, o_rx_data}, 32'h00);
    check("rst_busy",  {31'd0, o_busy}, 32'd0);
    check("rst_sclk",  {31'd0, o_sclk}, 32'd0);
    check("rst_mosi",  {31'd0, o_mosi}, 32'd0);
    check("rst_csn",   {28'd0, o_cs_n}, 32'hF);
    rst_n = 1'b1;
    tick();

    // 1: mode 0, MSB first, sel 2, H=2, loopback; exact timing
    f_loop = 1'b1;
    send(8'hA5, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1);
    tick();
    check("t1_csn",   {28'd0, o_cs_n}, 32'hB);
    check("t1_mosi0", {31'd0, o_mosi}, 32'd1);
    check("t1_sclk0", {31'd0, o_sclk}, 32'd0);
    check("t1_busy",  {31'd0, o_busy}, 32'd1);
    tick(); tick();
    check("t1_edge1", {31'd0, o_sclk}, 32'd1);
    for (int i = 0; i < 31; i++) tick();
    check("t1_rxv_early", {31'd0, o_rx_valid}, 32'd0);
    tick();
    check("t1_rxv", {31'd0, o_rx_valid}, 32'd1);
    check("t1_rxd", {24'd0, o_rx_data}, 32'hA5);
    tick();
    check("t1_rxv_pulse", {31'd0, o_rx_valid}, 32'd0);
    check("t1_gap_csn",   {28'd0, o_cs_n}, 32'hF);
    check("t1_gap_ready", {31'd0, o_tx_ready}, 32'd0);
    tick();
    check("t1_ready", {31'd0, o_tx_ready}, 32'd1);
    check("t1_idle",  {31'd0, o_busy}, 32'd0);

    // 2: modes 1..3 against the follower model sending 0x3C
    f_loop = 1'b0;
    f_word = 8'h3C;
    for (int m = 1; m < 4; m++) begin
      cpol = m[1];
      tick(); tick();
      check("t2_idle_pol", {31'd0, o_sclk}, {31'd0, m[1]});
      f_viol = 0;
      send(8'h96, 2'd0, m[1], m[0], 1'b0, 1'b0, 8'd2);
      wait_rx("t2", 200);
      check("t2_rxd",    {24'd0, o_rx_data}, 32'h3C);
      check("t2_follow", {24'd0, f_rx}, 32'h96);
      check("t2_edges",  f_viol, 32'd0);
      wait_idle("t2");
      check("t2_end_pol", {31'd0, o_sclk}, {31'd0, m[1]});
    end

    // 3: LSB first, tx 0x01 -> mosi high only for the first bit window (2H cycles)
    f_word = 8'h80;
    cpol = 1'b0;
    tick();
    m_mosi_hi = 0;
    send(8'h01, 2'd3, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1);
    wait_rx("t3", 200);
    check("t3_rxd",     {24'd0, o_rx_data}, 32'h80);
    check("t3_follow",  {24'd0, f_rx}, 32'h01);
    check("t3_mosi_hi", m_mosi_hi, 32'd4);
    wait_idle("t3");

    // 4: burst of three words on sel 1, sel change on word 2 ignored
    f_loop = 1'b1;
    send(8'h5A, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1);
    tick();
    mon_cs_bad = 0;
    mon_cs_exp = 4'b1101;
    mon_cs_en = 1'b1;
    wait_rx("t4w1", 200);
    check("t4_rxd1",   {24'd0, o_rx_data}, 32'h5A);
    check("t4_bready", {31'd0, o_tx_ready}, 32'd1);
    check("t4_bbusy",  {31'd0, o_busy}, 32'd1);
    send(8'hC3, 2'd3, 1'b1, 1'b1, 1'b0, 1'b1, 8'd2);
    wait_rx("t4w2", 200);
    check("t4_rxd2", {24'd0, o_rx_data}, 32'hC3);
    send(8'hFF, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
    wait_rx("t4w3", 200);
    mon_cs_en = 1'b0;
    check("t4_rxd3",   {24'd0, o_rx_data}, 32'hFF);
    check("t4_cs_low", mon_cs_bad, 32'd0);
    check("t4_gap",    {28'd0, o_cs_n}, 32'hF);
    wait_idle("t4");

    // 5: release together with tx_valid in BURST; H=3 gap, no accept
    send(8'h33, 2'd2, 1'b0, 1'b0, 1'b0, 1'b1, 8'd2);
    wait_rx("t5", 200);
    tx_data = 8'h77; tx_valid = 1'b1; cs_release = 1'b1;
    #1;
    check("t5_rel_ready", {31'd0, o_tx_ready}, 32'd0);
    tick();
    tx_valid = 1'b0; cs_release = 1'b0;
    check("t5_rel_csn", {28'd0, o_cs_n}, 32'hF);
    tick(); tick();
    check("t5_gap_busy", {31'd0, o_busy}, 32'd1);
    tick();
    check("t5_idle",  {31'd0, o_busy}, 32'd0);
    check("t5_ready", {31'd0, o_tx_ready}, 32'd1);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (o_rx_valid) pulses++;
    end
    check("t5_no_word", pulses, 32'd0);
    check("t5_rxd_kept", {24'd0, o_rx_data}, 32'h33);

    // 5b: cs_sel = NUM_CS on the three-select instance
    m3_bad = 0;
    mon3_en = 1'b1;
    send(8'h6B, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1);
    wait_rx("t5b", 200);
    check("t5b_rxv3",  {31'd0, o3_rx_valid}, 32'd1);
    check("t5b_rxd3",  {24'd0, o3_rx_data}, 32'h6B);
    check("t5b_busy3", {31'd0, o3_busy}, 32'd1);
    check("t5b_rdy3",  {31'd0, o3_tx_ready}, 32'd0);
    check("t5b_sclk3", {31'd0, o3_sclk}, 32'd0);
    mon3_en = 1'b0;
    check("t5b_no_cs", m3_bad, 32'd0);
    wait_idle("t5b");

    // 6: reset at sclk edge 7, then an H=1 word
    send(8'hA5, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1);
    for (int i = 0; i < 15; i++) tick();
    check("t6_edge7", {31'd0, o_sclk}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("t6_sclk",  {31'd0, o_sclk}, 32'd0);
    check("t6_csn",   {28'd0, o_cs_n}, 32'hF);
    check("t6_busy",  {31'd0, o_busy}, 32'd0);
    check("t6_ready", {31'd0, o_tx_ready}, 32'd1);
    check("t6_rxd",   {24'd0, o_rx_data}, 32'h00);
    tick(); tick();
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (o_rx_valid) pulses++;
    end
    check("t6_no_rxv", pulses, 32'd0);
    send(8'hC5, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    for (int i = 0; i < 17; i++) tick();
    check("t6_h1_early", {31'd0, o_rx_valid}, 32'd0);
    tick();
    check("t6_h1_rxv", {31'd0, o_rx_valid}, 32'd1);
    check("t6_h1_rxd", {24'd0, o_rx_data}, 32'hC5);
    tick();
    check("t6_h1_ready", {31'd0, o_tx_ready}, 32'd1);

    // 7: maximum divider, H = 256, rx_valid at T + 1 + 17*256
    send(8'h81, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd255);
    wait_rx("t7", 5000);
    check("t7_lat", t_rx - t_acc, 32'd4353);
    check("t7_rxd", {24'd0, o_rx_data}, 32'h81);
    wait_idle("t7");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
